// File: rtl/board_ram_arbiter.sv
// Single-port arbiter for the minesweeper board RAM: renderer reads, game
// read/write with starvation override, and a whole-board clear sequencer.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | normal arbitration between renderer and game side
// CLEAR | zeroing the board, one cell per free slot, game side blocked
module board_ram_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int STARVE_MAX = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r_req,
   input  logic [ADDR_W-1:0] r_addr,
   output logic              r_valid,
   output logic              r_miss,
   output logic [DATA_W-1:0] r_rdata,
   input  logic              g_req,
   input  logic              g_we,
   input  logic [ADDR_W-1:0] g_addr,
   input  logic [DATA_W-1:0] g_wdata,
   output logic              g_gnt,
   output logic              g_rvalid,
   output logic [DATA_W-1:0] g_rdata,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int                CNT_W    = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STARVE_MAX);
   localparam logic [ADDR_W-1:0] PTR_LAST = '1;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
   logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
   logic              override, r_slot, c_slot, g_slot;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         clr_ptr  <= '0;
         wait_cnt <= '0;
         r_valid  <= 1'b0;
         r_miss   <= 1'b0;
         g_rvalid <= 1'b0;
      end else begin
         state    <= state_nxt;
         clr_ptr  <= clr_ptr_nxt;
         wait_cnt <= wait_cnt_nxt;
         r_valid  <= r_slot;
         r_miss   <= r_req && override;
         g_rvalid <= g_slot && !g_we;
      end
   end

   always_comb begin
      override     = (state == IDLE) && g_req && (wait_cnt == CNT_MAX);
      r_slot       = r_req && !override;
      c_slot       = (state == CLEAR) && !r_req;
      g_slot       = override || ((state == IDLE) && g_req && !r_req);
      state_nxt    = state;
      clr_ptr_nxt  = clr_ptr;
      wait_cnt_nxt = '0;
      ram_addr     = '0;
      ram_we       = 1'b0;
      ram_wdata    = '0;

      if (g_slot) begin
         ram_addr  = g_addr;
         ram_we    = g_we;
         ram_wdata = g_wdata;
      end else if (r_slot) begin
         ram_addr  = r_addr;
      end else if (c_slot) begin
         ram_addr  = clr_ptr;
         ram_we    = 1'b1;
      end

      case (state)
         IDLE: begin
            if (clr_start)
               state_nxt = CLEAR;
            if (g_req && !g_slot)
               wait_cnt_nxt = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;
         end
         CLEAR: begin
            // a slot taken by the renderer just postpones this cell
            if (c_slot) begin
               clr_ptr_nxt = clr_ptr + 1'b1;
               if (clr_ptr == PTR_LAST)
                  state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign g_gnt    = g_slot;
   assign clr_busy = (state == CLEAR);
   assign r_rdata  = ram_rdata;
   assign g_rdata  = ram_rdata;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Directed bench for board_ram_arbiter with a behavioural synchronous RAM
// model attached to the RAM port.
module tb_board_ram_arbiter;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   localparam int CELLS  = 1 << ADDR_W;

   logic              clk, rst;
   logic              r_req, r_valid, r_miss;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_rdata;
   logic              g_req, g_we, g_gnt, g_rvalid;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_wdata, g_rdata;
   logic              clr_start, clr_busy;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;

   logic [DATA_W-1:0] mem [CELLS];
   logic              fill_en, poke_en;
   logic [DATA_W-1:0] fill_val, poke_val;
   logic [ADDR_W-1:0] poke_addr;

   int n_chk = 0;
   int n_err = 0;
   int gcyc, cnt, bad, nz, rv_bad;
   logic prev;

   board_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(15)) dut (
      .clk(clk), .rst(rst),
      .r_req(r_req), .r_addr(r_addr), .r_valid(r_valid), .r_miss(r_miss), .r_rdata(r_rdata),
      .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
      .g_gnt(g_gnt), .g_rvalid(g_rvalid), .g_rdata(g_rdata),
      .clr_start(clr_start), .clr_busy(clr_busy),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // read-first synchronous RAM, plus bench-side preload hooks
   always @(posedge clk) begin
      if (fill_en) begin
         for (int i = 0; i < CELLS; i++) mem[i] <= fill_val;
      end else if (poke_en) begin
         mem[poke_addr] <= poke_val;
      end else if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
      ram_rdata <= mem[ram_addr];
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic fill(input logic [DATA_W-1:0] v);
      fill_val = v;
      fill_en  = 1'b1;
      cyc();
      fill_en  = 1'b0;
   endtask

   task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
      poke_addr = a;
      poke_val  = v;
      poke_en   = 1'b1;
      cyc();
      poke_en   = 1'b0;
   endtask

   task automatic count_nonzero(output int n);
      n = 0;
      for (int i = 0; i < CELLS; i++) if (mem[i] !== '0) n++;
   endtask

   initial begin
      rst = 1'b0; r_req = 1'b0; r_addr = '0; g_req = 1'b0; g_we = 1'b0;
      g_addr = '0; g_wdata = '0; clr_start = 1'b0;
      fill_en = 1'b0; poke_en = 1'b0; fill_val = '0; poke_val = '0; poke_addr = '0;

      // reset values
      #2;
      check("rst_r_valid",  32'(r_valid),  0);
      check("rst_r_miss",   32'(r_miss),   0);
      check("rst_g_rvalid", 32'(g_rvalid), 0);
      check("rst_clr_busy", 32'(clr_busy), 0);
      check("rst_ram_we",   32'(ram_we),   0);
      check("rst_ram_addr", 32'(ram_addr), 0);
      cyc();
      rst = 1'b1;

      poke(8'h23, 8'h5A);
      poke(8'h05, 8'h33);
      poke(8'h40, 8'h77);

      // renderer read beats a pending game read
      r_req = 1'b1; r_addr = 8'h23; g_req = 1'b1; g_we = 1'b0; g_addr = 8'h05; #1;
      check("rd_gnt_blocked", 32'(g_gnt),    0);
      check("rd_ram_addr",    32'(ram_addr), 32'h23);
      check("rd_ram_we",      32'(ram_we),   0);
      cyc(); r_req = 1'b0; #1;
      check("rd_valid",       32'(r_valid),  1);
      check("rd_data",        32'(r_rdata),  32'h5A);
      check("rd_game_gnt",    32'(g_gnt),    1);
      check("rd_game_addr",   32'(ram_addr), 32'h05);
      cyc(); g_req = 1'b0; #1;
      check("g_rd_valid",     32'(g_rvalid), 1);
      check("g_rd_data",      32'(g_rdata),  32'h33);
      check("rd_valid_drop",  32'(r_valid),  0);

      // game write then read-back
      cyc(); g_req = 1'b1; g_we = 1'b1; g_addr = 8'h10; g_wdata = 8'h81; #1;
      check("wr_gnt",         32'(g_gnt),     1);
      check("wr_ram_we",      32'(ram_we),    1);
      check("wr_ram_wdata",   32'(ram_wdata), 32'h81);
      cyc(); g_we = 1'b0; #1;
      check("wrrd_gnt",       32'(g_gnt),    1);
      check("wr_no_rvalid",   32'(g_rvalid), 0);
      cyc(); g_req = 1'b0; #1;
      check("wrrd_rvalid",    32'(g_rvalid), 1);
      check("wrrd_data",      32'(g_rdata),  32'h81);

      // starvation override under continuous renderer load
      cyc(); r_req = 1'b1; r_addr = 8'h40; g_req = 1'b1; g_we = 1'b0; g_addr = 8'h23;
      gcyc = 0;
      for (int k = 1; k <= 20; k++) begin
         #1;
         if (g_gnt) begin gcyc = k; break; end
         cyc();
      end
      check("starve_gnt_cycle", 32'(gcyc), 16);
      check("starve_ram_addr",  32'(ram_addr), 32'h23);
      cyc(); g_req = 1'b0; #1;
      check("starve_r_miss",    32'(r_miss),   1);
      check("starve_r_valid",   32'(r_valid),  0);
      check("starve_g_rvalid",  32'(g_rvalid), 1);
      check("starve_g_rdata",   32'(g_rdata),  32'h5A);
      cyc(); #1;
      check("post_r_valid",     32'(r_valid),  1);
      check("post_r_miss",      32'(r_miss),   0);
      check("post_r_rdata",     32'(r_rdata),  32'h77);
      cyc(); g_req = 1'b1;
      gcyc = 0;
      for (int k = 1; k <= 20; k++) begin
         #1;
         if (g_gnt) begin gcyc = k; break; end
         cyc();
      end
      check("starve2_gnt_cycle", 32'(gcyc), 16);
      cyc(); g_req = 1'b0; r_req = 1'b0; #1;
      check("starve2_r_miss",    32'(r_miss), 1);

      // clear with no renderer traffic; game request shares the clr_start cycle
      cyc();
      fill(8'hFF);
      clr_start = 1'b1; g_req = 1'b1; g_we = 1'b1; g_addr = 8'h07; g_wdata = 8'h99; #1;
      check("clr_start_gnt",  32'(g_gnt),    1);
      check("clr_start_busy", 32'(clr_busy), 0);
      cyc(); clr_start = 1'b0; g_we = 1'b0; #1;
      check("clr_busy_rise",  32'(clr_busy),  1);
      check("clr_first_addr", 32'(ram_addr),  0);
      check("clr_first_we",   32'(ram_we),    1);
      check("clr_first_data", 32'(ram_wdata), 0);
      cnt = 0; bad = 0;
      for (int k = 0; k < 1000; k++) begin
         if (!clr_busy) break;
         cnt++;
         if (g_gnt) bad++;
         cyc(); #1;
      end
      check("clr_busy_len",   32'(cnt), 256);
      check("clr_no_g_gnt",   32'(bad), 0);
      check("clr_after_gnt",  32'(g_gnt), 1);
      cyc(); g_req = 1'b0; #1;
      check("clr_cell7_valid", 32'(g_rvalid), 1);
      check("clr_cell7_data",  32'(g_rdata),  0);
      count_nonzero(nz);
      check("clr_all_zero",    32'(nz), 0);

      // clear with renderer reads on alternate cycles
      cyc();
      fill(8'hFF);
      clr_start = 1'b1;
      cyc(); clr_start = 1'b0;
      cnt = 0; rv_bad = 0; prev = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         r_req = (k % 2 == 0); r_addr = 8'(k); #1;
         if (r_valid !== prev) rv_bad++;
         if (!clr_busy) break;
         cnt++;
         prev = r_req;
         cyc();
      end
      r_req = 1'b0;
      check("clr_load_len",    32'(cnt), 512);
      check("clr_load_rvalid", 32'(rv_bad), 0);
      cyc(); cyc();
      count_nonzero(nz);
      check("clr_load_zero",   32'(nz), 0);

      // asynchronous reset in the middle of a clear
      fill(8'hFF);
      clr_start = 1'b1;
      cyc(); clr_start = 1'b0;
      repeat (100) cyc();
      #1;
      check("mid_clr_addr", 32'(ram_addr), 100);
      check("mid_clr_we",   32'(ram_we),   1);
      rst = 1'b0; #1;
      check("mid_rst_busy",   32'(clr_busy), 0);
      check("mid_rst_we",     32'(ram_we),   0);
      check("mid_rst_addr",   32'(ram_addr), 0);
      check("mid_rst_rvalid", 32'(r_valid),  0);
      check("mid_rst_grv",    32'(g_rvalid), 0);
      check("mid_rst_cell50", 32'(mem[50]),  0);
      check("mid_rst_cell150",32'(mem[150]), 32'hFF);
      cyc(); rst = 1'b1;
      cyc(); clr_start = 1'b1;
      cyc(); clr_start = 1'b0; #1;
      check("restart_busy", 32'(clr_busy), 1);
      check("restart_addr", 32'(ram_addr), 0);
      check("restart_we",   32'(ram_we),   1);
      cnt = 0;
      for (int k = 0; k < 1000; k++) begin
         if (!clr_busy) break;
         cnt++;
         cyc(); #1;
      end
      check("restart_len", 32'(cnt), 256);
      cyc();
      count_nonzero(nz);
      check("restart_zero", 32'(nz), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
